// File: rtl/bypass_ctrl_pkg.sv
// Shared definitions for the ID-stage operand bypass / load-use interlock unit:
// default depth, forwarding-source encodings and named ready-stage constants.
package bypass_ctrl_pkg;

  // Default number of tracked downstream stages (EX, MM1, MM2, WB).
  localparam int DEPTH_DEF = 4;

  // Forwarding source encodings: 0 selects the register file, k+1 selects stage k.
  localparam int FWD_SRC_GR  = 0;
  localparam int FWD_SRC_EX  = 1;
  localparam int FWD_SRC_MM1 = 2;
  localparam int FWD_SRC_MM2 = 3;
  localparam int FWD_SRC_WB  = 4;

  // First stage index at which a producer's result exists.
  localparam int RDY_EX  = 0;
  localparam int RDY_MM1 = 1;
  localparam int RDY_MM2 = 2;

  // Forwarding-source code for a producer sitting in stage k.
  function automatic int fwd_src_of_stage(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/bypass_port_sel.sv
// Priority match and operand mux for a single ID read port. The youngest
// (lowest-index) valid entry whose destination equals the source register
// wins; if its result is not yet available the port is flagged hazardous.
module bypass_port_sel
  import bypass_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int RW    = 5,
  parameter int DW    = 32,
  parameter int SW    = $clog2(DEPTH + 1),
  parameter int RSW   = $clog2(DEPTH)
) (
  input  logic                 rd_en,
  input  logic [RW-1:0]        rd_addr,
  input  logic [DEPTH-1:0]     ent_v,
  input  logic [DEPTH*RW-1:0]  ent_addr,
  input  logic [DEPTH*RSW-1:0] ent_rdy,
  input  logic [DW-1:0]        gr_data,
  input  logic [DEPTH*DW-1:0]  stage_res,
  output logic [DW-1:0]        rd_data,
  output logic [SW-1:0]        fwd_src,
  output logic                 hazard
);

  logic [DEPTH-1:0] hit_s;
  logic [RSW-1:0]   sel_s;
  logic             any_hit_s;
  logic [DW-1:0]    data_s;
  logic [SW-1:0]    src_s;
  logic             haz_s;

  // Per-entry match vector; r0 and disabled ports never match.
  always_comb begin
    hit_s = {DEPTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      hit_s[k] = rd_en && (rd_addr != {RW{1'b0}}) && ent_v[k] &&
                 (ent_addr[k*RW +: RW] == rd_addr);
    end
  end

  // Priority encode: scanning from oldest to youngest lets the youngest hit win.
  always_comb begin
    sel_s = {RSW{1'b0}};
    for (int k = DEPTH - 1; k >= 0; k--) begin
      sel_s = hit_s[k] ? RSW'(k) : sel_s;
    end
    any_hit_s = |hit_s;
  end

  // Operand selection and hazard flag for the winning producer.
  always_comb begin
    data_s = gr_data;
    src_s  = SW'(FWD_SRC_GR);
    haz_s  = 1'b0;
    if (any_hit_s) begin
      src_s = SW'(fwd_src_of_stage(int'(sel_s)));
      // Winning data is driven either way; it is only meaningful when available.
      data_s = stage_res[sel_s*DW +: DW];
      if (ent_rdy[sel_s*RSW +: RSW] <= sel_s) begin
        haz_s = 1'b0;
      end else begin
        haz_s = 1'b1;
      end
    end else begin
      data_s = gr_data;
      src_s  = SW'(FWD_SRC_GR);
      haz_s  = 1'b0;
    end
  end

  assign rd_data = data_s;
  assign fwd_src = src_s;
  assign hazard  = haz_s;

endmodule

// File: rtl/bypass_ctrl.sv
// Operand-bypass and load-use interlock unit for the ID stage. A shadow
// pipeline of in-flight register writers (one entry per downstream stage)
// drives per-port forwarding selection and the interlock; stalled cycles
// are counted for performance monitoring.
module bypass_ctrl
  import bypass_ctrl_pkg::*;
#(
  parameter int NRD          = 2,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int RW           = 5,
  parameter int DW           = 32,
  parameter int FLUSH_STAGES = 1,
  parameter int SW           = $clog2(DEPTH + 1),
  parameter int RSW          = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pipe_go,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [NRD-1:0]       id_rd_en,
  input  logic [NRD*RW-1:0]    id_rd_addr,
  input  logic                 id_wr_en,
  input  logic [RW-1:0]        id_wr_addr,
  input  logic [RSW-1:0]       id_ready_stage,
  input  logic [NRD*DW-1:0]    gr_data,
  input  logic [DEPTH*DW-1:0]  stage_res,
  output logic [NRD*DW-1:0]    rd_data,
  output logic [NRD*SW-1:0]    fwd_src,
  output logic                 stall,
  output logic [31:0]          stall_cnt
);

  // Flush never reaches past the tracked depth.
  localparam int FL = (FLUSH_STAGES > DEPTH) ? DEPTH : FLUSH_STAGES;
  localparam logic [DEPTH-1:0] FLUSH_MASK = DEPTH'((64'd1 << FL) - 64'd1);

  logic [DEPTH-1:0]     ent_v_r;
  logic [DEPTH*RW-1:0]  ent_addr_r;
  logic [DEPTH*RSW-1:0] ent_rdy_r;

  logic [DEPTH-1:0]     ent_v_nxt_s;
  logic [DEPTH*RW-1:0]  ent_addr_nxt_s;
  logic [DEPTH*RSW-1:0] ent_rdy_nxt_s;

  logic [NRD-1:0]       hazard_s;
  logic                 stall_s;
  logic                 wr_new_s;
  logic [31:0]          stall_cnt_r;

  // One priority match/mux per read port.
  for (genvar p = 0; p < NRD; p++) begin : g_port
    bypass_port_sel #(
      .DEPTH (DEPTH),
      .RW    (RW),
      .DW    (DW),
      .SW    (SW),
      .RSW   (RSW)
    ) u_sel (
      .rd_en     (id_rd_en[p]),
      .rd_addr   (id_rd_addr[p*RW +: RW]),
      .ent_v     (ent_v_r),
      .ent_addr  (ent_addr_r),
      .ent_rdy   (ent_rdy_r),
      .gr_data   (gr_data[p*DW +: DW]),
      .stage_res (stage_res),
      .rd_data   (rd_data[p*DW +: DW]),
      .fwd_src   (fwd_src[p*SW +: SW]),
      .hazard    (hazard_s[p])
    );
  end

  assign stall_s = id_valid && (|hazard_s);
  // A stalled or r0-targeting instruction enters EX as a bubble.
  assign wr_new_s = id_valid && !stall_s && id_wr_en && (id_wr_addr != {RW{1'b0}});

  // Shadow pipeline next state: shift on pipe_go, then flush kills the youngest stages.
  always_comb begin
    ent_v_nxt_s    = ent_v_r;
    ent_addr_nxt_s = ent_addr_r;
    ent_rdy_nxt_s  = ent_rdy_r;
    if (pipe_go) begin
      ent_v_nxt_s    = {ent_v_r[DEPTH-2:0], wr_new_s};
      ent_addr_nxt_s = {ent_addr_r[(DEPTH-1)*RW-1:0], id_wr_addr};
      ent_rdy_nxt_s  = {ent_rdy_r[(DEPTH-1)*RSW-1:0], id_ready_stage};
    end else begin
      ent_v_nxt_s    = ent_v_r;
      ent_addr_nxt_s = ent_addr_r;
      ent_rdy_nxt_s  = ent_rdy_r;
    end
    if (flush) begin
      ent_v_nxt_s = ent_v_nxt_s & ~FLUSH_MASK;
    end else begin
      ent_v_nxt_s = ent_v_nxt_s & {DEPTH{1'b1}};
    end
  end

  // Shadow pipeline state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ent_v_r    <= {DEPTH{1'b0}};
      ent_addr_r <= {(DEPTH*RW){1'b0}};
      ent_rdy_r  <= {(DEPTH*RSW){1'b0}};
    end else begin
      ent_v_r    <= ent_v_nxt_s;
      ent_addr_r <= ent_addr_nxt_s;
      ent_rdy_r  <= ent_rdy_nxt_s;
    end
  end

  // Saturating count of interlock cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall     = stall_s;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_bypass_ctrl.sv
// Scoreboard bench for bypass_ctrl: expectations are queued when stimulus is
// driven and popped/compared once the combinational outputs have settled.
module tb_bypass_ctrl;
  import bypass_ctrl_pkg::*;

  localparam logic [31:0] GR0 = 32'h0000_00A0;
  localparam logic [31:0] GR1 = 32'h0000_00B1;
  localparam logic [31:0] S0  = 32'h1234_5678;
  localparam logic [31:0] S1  = 32'hAAAA_0001;
  localparam logic [31:0] S2  = 32'hBBBB_0002;
  localparam logic [31:0] S3  = 32'hCCCC_0003;

  localparam int K_FWD0 = 0, K_FWD1 = 1, K_STALL = 2, K_RD0 = 3, K_RD1 = 4, K_CNT = 5;

  logic         clk = 1'b0;
  logic         resetn;
  logic         pipe_go;
  logic         flush;
  logic         id_valid;
  logic [1:0]   id_rd_en;
  logic [9:0]   id_rd_addr;
  logic         id_wr_en;
  logic [4:0]   id_wr_addr;
  logic [1:0]   id_ready_stage;
  logic [63:0]  gr_data;
  logic [127:0] stage_res;
  logic [63:0]  rd_data;
  logic [5:0]   fwd_src;
  logic         stall;
  logic [31:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          kind;
    logic [63:0] exp;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  bypass_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .pipe_go        (pipe_go),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_rd_en       (id_rd_en),
    .id_rd_addr     (id_rd_addr),
    .id_wr_en       (id_wr_en),
    .id_wr_addr     (id_wr_addr),
    .id_ready_stage (id_ready_stage),
    .gr_data        (gr_data),
    .stage_res      (stage_res),
    .rd_data        (rd_data),
    .fwd_src        (fwd_src),
    .stall          (stall),
    .stall_cnt      (stall_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int kind, input logic [63:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Let outputs settle, then drain the scoreboard against the DUT.
  task automatic sample();
    exp_t        e;
    logic [63:0] obs;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_FWD0:  obs = 64'(fwd_src[2:0]);
        K_FWD1:  obs = 64'(fwd_src[5:3]);
        K_STALL: obs = 64'(stall);
        K_RD0:   obs = 64'(rd_data[31:0]);
        K_RD1:   obs = 64'(rd_data[63:32]);
        K_CNT:   obs = 64'(stall_cnt);
        default: obs = 64'hDEAD_DEAD_DEAD_DEAD;
      endcase
      check_val(e.tag, obs, e.exp);
    end
  endtask

  task automatic drive(input logic v, input logic wen, input logic [4:0] waddr,
                       input int rdy, input logic [1:0] ren,
                       input logic [4:0] a0, input logic [4:0] a1);
    id_valid       = v;
    id_wr_en       = wen;
    id_wr_addr     = waddr;
    id_ready_stage = 2'(rdy);
    id_rd_en       = ren;
    id_rd_addr     = {a1, a0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, 5'd0, RDY_EX, 2'b00, 5'd0, 5'd0);
    repeat (4) tick();
  endtask

  initial begin
    resetn    = 1'b0;
    pipe_go   = 1'b1;
    flush     = 1'b0;
    gr_data   = {GR1, GR0};
    stage_res = {S3, S2, S1, S0};
    drive(1'b1, 1'b0, 5'd0, RDY_EX, 2'b11, 5'd5, 5'd7);
    #2;
    push_exp("rst_fwd0", K_FWD0, 64'd0);
    push_exp("rst_fwd1", K_FWD1, 64'd0);
    push_exp("rst_stall", K_STALL, 64'd0);
    push_exp("rst_cnt", K_CNT, 64'd0);
    push_exp("rst_rd0", K_RD0, 64'(GR0));
    push_exp("rst_rd1", K_RD1, 64'(GR1));
    sample();
    resetn = 1'b1;
    tick();

    // ALU producer r5 forwarded from EX
    drive(1'b1, 1'b1, 5'd5, RDY_EX, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, RDY_EX, 2'b11, 5'd5, 5'd1);
    push_exp("alu_fwd0", K_FWD0, 64'(FWD_SRC_EX));
    push_exp("alu_rd0", K_RD0, 64'(S0));
    push_exp("alu_fwd1", K_FWD1, 64'(FWD_SRC_GR));
    push_exp("alu_rd1", K_RD1, 64'(GR1));
    push_exp("alu_stall", K_STALL, 64'd0);
    sample();
    tick();
    drain();

    // Load-use on r7: two stall cycles, then bypass from MM2
    drive(1'b1, 1'b1, 5'd7, RDY_MM2, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, RDY_EX, 2'b10, 5'd0, 5'd7);
    push_exp("ld_stall_a", K_STALL, 64'd1);
    push_exp("ld_fwd_a", K_FWD1, 64'(FWD_SRC_EX));
    sample();
    tick();
    push_exp("ld_stall_b", K_STALL, 64'd1);
    push_exp("ld_fwd_b", K_FWD1, 64'(FWD_SRC_MM1));
    push_exp("ld_cnt_b", K_CNT, 64'd1);
    sample();
    tick();
    push_exp("ld_stall_c", K_STALL, 64'd0);
    push_exp("ld_fwd_c", K_FWD1, 64'(FWD_SRC_MM2));
    push_exp("ld_rd_c", K_RD1, 64'(S2));
    push_exp("ld_cnt_c", K_CNT, 64'd2);
    sample();
    tick();
    drain();

    // Two available writers to r3: youngest (EX) wins
    drive(1'b1, 1'b1, 5'd3, RDY_EX, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, RDY_EX, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd3, RDY_EX, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, RDY_EX, 2'b01, 5'd3, 5'd0);
    push_exp("yng_fwd0", K_FWD0, 64'(FWD_SRC_EX));
    push_exp("yng_rd0", K_RD0, 64'(S0));
    push_exp("yng_stall", K_STALL, 64'd0);
    sample();
    tick();
    drain();

    // Youngest r4 unavailable while older r4 is available: still stalls
    drive(1'b1, 1'b1, 5'd4, RDY_EX, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, RDY_EX, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd4, RDY_MM2, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, RDY_EX, 2'b01, 5'd4, 5'd0);
    push_exp("multi_stall", K_STALL, 64'd1);
    push_exp("multi_fwd0", K_FWD0, 64'(FWD_SRC_EX));
    sample();
    tick();
    drain();
    push_exp("multi_cnt", K_CNT, 64'd3);
    sample();

    // r0 writer in flight: r0 reads never bypass
    drive(1'b1, 1'b1, 5'd0, RDY_MM2, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, RDY_EX, 2'b11, 5'd0, 5'd0);
    push_exp("r0_fwd0", K_FWD0, 64'(FWD_SRC_GR));
    push_exp("r0_fwd1", K_FWD1, 64'(FWD_SRC_GR));
    push_exp("r0_stall", K_STALL, 64'd0);
    push_exp("r0_rd0", K_RD0, 64'(GR0));
    push_exp("r0_rd1", K_RD1, 64'(GR1));
    sample();
    tick();
    drain();

    // Flush kills the load to r9 entering EX
    flush = 1'b1;
    drive(1'b1, 1'b1, 5'd9, RDY_MM2, 2'b00, 5'd0, 5'd0);
    tick();
    flush = 1'b0;
    drive(1'b1, 1'b0, 5'd0, RDY_EX, 2'b11, 5'd9, 5'd9);
    push_exp("fl_fwd0", K_FWD0, 64'(FWD_SRC_GR));
    push_exp("fl_fwd1", K_FWD1, 64'(FWD_SRC_GR));
    push_exp("fl_stall", K_STALL, 64'd0);
    push_exp("fl_rd0", K_RD0, 64'(GR0));
    sample();
    tick();
    drain();

    // Writer in WB, reader in ID same cycle: bypass from stage DEPTH-1
    drive(1'b1, 1'b1, 5'd13, RDY_EX, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, RDY_EX, 2'b00, 5'd0, 5'd0);
    repeat (3) tick();
    drive(1'b1, 1'b0, 5'd0, RDY_EX, 2'b10, 5'd0, 5'd13);
    push_exp("wb_fwd1", K_FWD1, 64'(FWD_SRC_WB));
    push_exp("wb_rd1", K_RD1, 64'(S3));
    push_exp("wb_stall", K_STALL, 64'd0);
    sample();
    tick();
    drain();

    // pipe_go low for 3 cycles during a load-use hazard on r11
    drive(1'b1, 1'b1, 5'd11, RDY_MM2, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, RDY_EX, 2'b01, 5'd11, 5'd0);
    push_exp("hold_stall0", K_STALL, 64'd1);
    push_exp("hold_fwd0", K_FWD0, 64'(FWD_SRC_EX));
    sample();
    pipe_go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      push_exp("hold_stall", K_STALL, 64'd1);
      push_exp("hold_fwd", K_FWD0, 64'(FWD_SRC_EX));
      sample();
    end
    push_exp("hold_cnt", K_CNT, 64'd6);
    sample();
    pipe_go = 1'b1;
    tick();
    push_exp("go_stall1", K_STALL, 64'd1);
    push_exp("go_fwd1", K_FWD0, 64'(FWD_SRC_MM1));
    push_exp("go_cnt1", K_CNT, 64'd7);
    sample();
    tick();
    push_exp("go_stall2", K_STALL, 64'd0);
    push_exp("go_fwd2", K_FWD0, 64'(FWD_SRC_MM2));
    push_exp("go_rd2", K_RD0, 64'(S2));
    push_exp("go_cnt2", K_CNT, 64'd8);
    sample();
    tick();
    drain();

    // Async reset while a hazard is pending
    drive(1'b1, 1'b1, 5'd12, RDY_MM2, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, RDY_EX, 2'b10, 5'd0, 5'd12);
    push_exp("pre_rst_stall", K_STALL, 64'd1);
    push_exp("pre_rst_fwd1", K_FWD1, 64'(FWD_SRC_EX));
    sample();
    resetn = 1'b0;
    push_exp("mrst_fwd0", K_FWD0, 64'd0);
    push_exp("mrst_fwd1", K_FWD1, 64'd0);
    push_exp("mrst_stall", K_STALL, 64'd0);
    push_exp("mrst_cnt", K_CNT, 64'd0);
    push_exp("mrst_rd1", K_RD1, 64'(GR1));
    sample();
    resetn = 1'b1;
    tick();
    push_exp("post_rst_stall", K_STALL, 64'd0);
    push_exp("post_rst_fwd1", K_FWD1, 64'd0);
    sample();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
